// File: rtl/hazard_ctrl.sv
// hazard_ctrl: ID-stage sequencing controller for the 5-stage RV32I core.
// A shadow scoreboard tracks the destination registers in EX/MEM/WB. From it
// the block derives the ID forward selects, the load-use and ALU-use stalls,
// the IF/ID flush for taken jumps, the ebreak drain/halt state machine and
// the performance counters.
module hazard_ctrl #(
    parameter int CNT_W  = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs0,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic              id_use_rs0,
    input  logic              id_use_rs1,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_to_reg,
    input  logic              id_jump,
    input  logic              id_ebreak,
    input  logic              resume,
    output logic              forward_sel0,
    output logic              forward_sel1,
    output logic              forward_src0,
    output logic              forward_src1,
    output logic              pc_stall,
    output logic              ifid_stall,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              halted,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t r_state;
    state_t w_state_nxt;

    // Scoreboard: _p0 = EX, _p1 = MEM, _p2 = WB.
    logic              r_vld_p0;
    logic              r_vld_p1;
    logic              r_vld_p2;
    logic [REG_AW-1:0] r_rd_p0;
    logic [REG_AW-1:0] r_rd_p1;
    logic [REG_AW-1:0] r_rd_p2;
    logic              r_wr_p0;
    logic              r_wr_p1;
    logic              r_wr_p2;
    // The load flag only matters in EX (to shift it on) and MEM (load-use
    // stall); a load that reached WB is forwarded from WB_din like any result.
    logic              r_m2r_p0;
    logic              r_m2r_p1;

    logic [CNT_W-1:0]  r_cycle_cnt;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic              w_prod_p0;
    logic              w_prod_p1;
    logic              w_prod_p2;
    logic              w_need0;
    logic              w_need1;
    logic [2:0]        w_res0;
    logic [2:0]        w_res1;
    logic              w_hazard;
    logic              w_data_stall;
    logic              w_pc_stall;
    logic              w_ifid_stall;
    logic              w_ifid_flush;
    logic              w_idex_bubble;
    logic              w_halted;

    // An entry only produces a value if it is real, writes, and is not x0.
    function automatic logic f_producer(
        input logic              vld,
        input logic              wr,
        input logic [REG_AW-1:0] rd
    );
        return vld && wr && (rd != '0);
    endfunction

    // Resolve one source against the matching producers, youngest first.
    // Returns {stall, forward_sel, forward_src}.
    function automatic logic [2:0] f_resolve(
        input logic need,
        input logic m_ex,
        input logic m_mem,
        input logic mem_is_load,
        input logic m_wb
    );
        logic [2:0] res;
        res = 3'b000;
        if (need) begin
            if (m_ex) begin
                res = 3'b100;          // result not ready until end of EX
            end else if (m_mem && mem_is_load) begin
                res = 3'b100;          // load data not ready until WB
            end else if (m_mem) begin
                res = 3'b010;          // forward MEM ALU result
            end else if (m_wb) begin
                res = 3'b011;          // forward WB_din
            end
        end
        return res;
    endfunction

    assign w_prod_p0 = f_producer(r_vld_p0, r_wr_p0, r_rd_p0);
    assign w_prod_p1 = f_producer(r_vld_p1, r_wr_p1, r_rd_p1);
    assign w_prod_p2 = f_producer(r_vld_p2, r_wr_p2, r_rd_p2);

    assign w_need0 = id_valid && id_use_rs0 && (id_rs0 != '0);
    assign w_need1 = id_valid && id_use_rs1 && (id_rs1 != '0);

    assign w_res0 = f_resolve(w_need0,
                              w_prod_p0 && (r_rd_p0 == id_rs0),
                              w_prod_p1 && (r_rd_p1 == id_rs0),
                              r_m2r_p1,
                              w_prod_p2 && (r_rd_p2 == id_rs0));

    assign w_res1 = f_resolve(w_need1,
                              w_prod_p0 && (r_rd_p0 == id_rs1),
                              w_prod_p1 && (r_rd_p1 == id_rs1),
                              r_m2r_p1,
                              w_prod_p2 && (r_rd_p2 == id_rs1));

    assign w_hazard = w_res0[2] || w_res1[2];

    // Next state and stall/flush/bubble decode for RUN, DRAIN and HALTED.
    always_comb begin
        w_state_nxt   = r_state;
        w_data_stall  = 1'b0;
        w_pc_stall    = 1'b0;
        w_ifid_stall  = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_bubble = 1'b0;
        w_halted      = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_data_stall = w_hazard;
                if (w_data_stall) begin
                    // Compare operands are stale, so a jump here is ignored.
                    w_pc_stall    = 1'b1;
                    w_ifid_stall  = 1'b1;
                    w_idex_bubble = 1'b1;
                end else begin
                    w_ifid_flush = id_valid && id_jump;
                    if (id_valid && id_ebreak) begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                w_pc_stall    = 1'b1;
                w_ifid_stall  = 1'b1;
                w_idex_bubble = 1'b1;
                // EX receives a bubble and WB is overwritten by MEM on this
                // edge, so the scoreboard is empty on entry to HALTED.
                if (!r_vld_p0 && !r_vld_p1) begin
                    w_state_nxt = ST_HALTED;
                end
            end
            ST_HALTED: begin
                w_pc_stall    = 1'b1;
                w_ifid_stall  = 1'b1;
                w_idex_bubble = 1'b1;
                w_halted      = 1'b1;
                if (resume) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Scoreboard valid bits: EX takes the ID instruction unless a bubble is
    // inserted; MEM and WB shift every clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p0 <= 1'b0;
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
        end else begin
            r_vld_p0 <= id_valid && !w_idex_bubble;
            r_vld_p1 <= r_vld_p0;
            r_vld_p2 <= r_vld_p1;
        end
    end

    // Scoreboard payload; only meaningful where the matching valid bit is set.
    always_ff @(posedge clk) begin
        r_rd_p0  <= id_rd;
        r_wr_p0  <= id_reg_write;
        r_m2r_p0 <= id_mem_to_reg;
        r_rd_p1  <= r_rd_p0;
        r_wr_p1  <= r_wr_p0;
        r_m2r_p1 <= r_m2r_p0;
        r_rd_p2  <= r_rd_p1;
        r_wr_p2  <= r_wr_p1;
    end

    // Performance counters, wrapping modulo 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle_cnt <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + CNT_ONE;
            if (w_data_stall) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
            if (w_ifid_flush) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end
        end
    end

    assign forward_sel0 = w_res0[1];
    assign forward_src0 = w_res0[0];
    assign forward_sel1 = w_res1[1];
    assign forward_src1 = w_res1[0];
    assign pc_stall     = w_pc_stall;
    assign ifid_stall   = w_ifid_stall;
    assign ifid_flush   = w_ifid_flush;
    assign idex_bubble  = w_idex_bubble;
    assign halted       = w_halted;
    assign cycle_cnt    = r_cycle_cnt;
    assign stall_cnt    = r_stall_cnt;
    assign flush_cnt    = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed, table-driven bench for hazard_ctrl plus
// hand-written sequences for ebreak drain/halt/resume and reset in DRAIN.
module tb_hazard_ctrl;

    localparam int CNT_W  = 32;
    localparam int REG_AW = 5;

    logic              clk;
    logic              rst;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs0;
    logic [REG_AW-1:0] id_rs1;
    logic              id_use_rs0;
    logic              id_use_rs1;
    logic [REG_AW-1:0] id_rd;
    logic              id_reg_write;
    logic              id_mem_to_reg;
    logic              id_jump;
    logic              id_ebreak;
    logic              resume;
    logic              forward_sel0;
    logic              forward_sel1;
    logic              forward_src0;
    logic              forward_src1;
    logic              pc_stall;
    logic              ifid_stall;
    logic              ifid_flush;
    logic              idex_bubble;
    logic              halted;
    logic [CNT_W-1:0]  cycle_cnt;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    hazard_ctrl #(.CNT_W(CNT_W), .REG_AW(REG_AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs0       (id_rs0),
        .id_rs1       (id_rs1),
        .id_use_rs0   (id_use_rs0),
        .id_use_rs1   (id_use_rs1),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_to_reg(id_mem_to_reg),
        .id_jump      (id_jump),
        .id_ebreak    (id_ebreak),
        .resume       (resume),
        .forward_sel0 (forward_sel0),
        .forward_sel1 (forward_sel1),
        .forward_src0 (forward_src0),
        .forward_src1 (forward_src1),
        .pc_stall     (pc_stall),
        .ifid_stall   (ifid_stall),
        .ifid_flush   (ifid_flush),
        .idex_bubble  (idex_bubble),
        .halted       (halted),
        .cycle_cnt    (cycle_cnt),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    typedef struct {
        logic              v;
        logic [REG_AW-1:0] rs0;
        logic [REG_AW-1:0] rs1;
        logic              u0;
        logic              u1;
        logic [REG_AW-1:0] rd;
        logic              wr;
        logic              m2r;
        logic              jmp;
        logic              e_sel0;
        logic              e_sel1;
        logic              e_src0;
        logic              e_src1;
        logic              e_stall;
        logic              e_flush;
        logic [CNT_W-1:0]  e_sc;
        logic [CNT_W-1:0]  e_fc;
    } vec_t;

    vec_t tbl[$];
    int   n_err     = 0;
    int   n_chk     = 0;
    int   tb_cycles = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b, expected %0b", name, act, exp);
        end
    endtask

    task automatic chkc(input string name, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_ctrl(input string tag, input logic st, input logic fl, input logic h);
        chk1({tag, " pc_stall"},    pc_stall,    st);
        chk1({tag, " ifid_stall"},  ifid_stall,  st);
        chk1({tag, " idex_bubble"}, idex_bubble, st);
        chk1({tag, " ifid_flush"},  ifid_flush,  fl);
        chk1({tag, " halted"},      halted,      h);
    endtask

    task automatic chk_fwd(input string tag, input logic s0, input logic s1, input logic c0, input logic c1);
        chk1({tag, " sel0"}, forward_sel0, s0);
        chk1({tag, " sel1"}, forward_sel1, s1);
        chk1({tag, " src0"}, forward_src0, c0);
        chk1({tag, " src1"}, forward_src1, c1);
    endtask

    function automatic vec_t mk(input int v, input int rs0, input int rs1, input int u0, input int u1,
                                input int rd, input int wr, input int m2r, input int jmp,
                                input int s0, input int s1, input int c0, input int c1,
                                input int st, input int fl, input int sc, input int fc);
        vec_t r;
        r.v       = v[0];
        r.rs0     = rs0[REG_AW-1:0];
        r.rs1     = rs1[REG_AW-1:0];
        r.u0      = u0[0];
        r.u1      = u1[0];
        r.rd      = rd[REG_AW-1:0];
        r.wr      = wr[0];
        r.m2r     = m2r[0];
        r.jmp     = jmp[0];
        r.e_sel0  = s0[0];
        r.e_sel1  = s1[0];
        r.e_src0  = c0[0];
        r.e_src1  = c1[0];
        r.e_stall = st[0];
        r.e_flush = fl[0];
        r.e_sc    = CNT_W'(sc);
        r.e_fc    = CNT_W'(fc);
        return r;
    endfunction

    task automatic set_in(input int v, input int rs0, input int rs1, input int u0, input int u1,
                          input int rd, input int wr, input int m2r, input int jmp, input int eb);
        id_valid      = v[0];
        id_rs0        = rs0[REG_AW-1:0];
        id_rs1        = rs1[REG_AW-1:0];
        id_use_rs0    = u0[0];
        id_use_rs1    = u1[0];
        id_rd         = rd[REG_AW-1:0];
        id_reg_write  = wr[0];
        id_mem_to_reg = m2r[0];
        id_jump       = jmp[0];
        id_ebreak     = eb[0];
    endtask

    task automatic apply_vec(input vec_t t);
        id_valid      = t.v;
        id_rs0        = t.rs0;
        id_rs1        = t.rs1;
        id_use_rs0    = t.u0;
        id_use_rs1    = t.u1;
        id_rd         = t.rd;
        id_reg_write  = t.wr;
        id_mem_to_reg = t.m2r;
        id_jump       = t.jmp;
        id_ebreak     = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (!rst) tb_cycles++;
    endtask

    initial begin
        rst    = 1'b1;
        resume = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        @(negedge clk);
        chk_ctrl("reset", 1'b0, 1'b0, 1'b0);
        chk_fwd("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        chkc("reset cycle_cnt", cycle_cnt, CNT_W'(0));
        chkc("reset stall_cnt", stall_cnt, CNT_W'(0));
        chkc("reset flush_cnt", flush_cnt, CNT_W'(0));
        tick();
        rst = 1'b0;
        tb_cycles = 0;

        //          v rs0 rs1 u0 u1 rd wr m2r jmp  s0 s1 c0 c1 st fl  sc fc
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0)); // idle
        tbl.push_back(mk(1, 0, 0, 1, 0, 5, 1, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0)); // addi x5,x0,3
        tbl.push_back(mk(1, 5, 5, 1, 1, 6, 1, 0, 0,  0, 0, 0, 0, 1, 0,  0, 0)); // add x6,x5,x5: EX hit
        tbl.push_back(mk(1, 5, 5, 1, 1, 6, 1, 0, 0,  1, 1, 0, 0, 0, 0,  1, 0)); // retry: MEM fwd
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 7, 1, 1, 0,  0, 0, 0, 0, 0, 0,  1, 0)); // lw x7,0(x0)
        tbl.push_back(mk(1, 7, 0, 1, 1, 0, 0, 0, 1,  0, 0, 0, 0, 1, 0,  1, 0)); // beq x7,x0: EX hit
        tbl.push_back(mk(1, 7, 0, 1, 1, 0, 0, 0, 1,  0, 0, 0, 0, 1, 0,  2, 0)); // MEM load hit
        tbl.push_back(mk(1, 7, 0, 1, 1, 0, 0, 0, 1,  1, 0, 1, 0, 0, 1,  3, 0)); // WB fwd + flush
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  3, 1));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0,  3, 1)); // addi x0,x0,1
        tbl.push_back(mk(1, 0, 0, 1, 1, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0,  3, 1)); // add x1,x0,x0
        tbl.push_back(mk(1, 0, 0, 0, 0, 5, 0, 0, 0,  0, 0, 0, 0, 0, 0,  3, 1)); // store, rd field 5
        tbl.push_back(mk(1, 5, 1, 1, 0, 2, 1, 0, 0,  0, 0, 0, 0, 0, 0,  3, 1)); // non-writer / unused rs1
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  3, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  3, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  3, 1));
        tbl.push_back(mk(1, 0, 0, 1, 0, 3, 1, 0, 0,  0, 0, 0, 0, 0, 0,  3, 1)); // addi x3 (older)
        tbl.push_back(mk(1, 0, 0, 1, 0, 3, 1, 0, 0,  0, 0, 0, 0, 0, 0,  3, 1)); // addi x3 (younger)
        tbl.push_back(mk(1, 0, 3, 1, 1, 4, 1, 0, 0,  0, 0, 0, 0, 1, 0,  3, 1)); // add x4,x0,x3: EX wins
        tbl.push_back(mk(1, 0, 3, 1, 1, 4, 1, 0, 0,  0, 1, 0, 0, 0, 0,  4, 1)); // MEM wins over WB
        tbl.push_back(mk(1, 0, 0, 1, 0, 8, 1, 0, 0,  0, 0, 0, 0, 0, 0,  4, 1)); // addi x8
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  4, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  4, 1));
        tbl.push_back(mk(1, 0, 8, 1, 1, 9, 1, 0, 0,  0, 1, 0, 1, 0, 0,  4, 1)); // add x9,x0,x8: WB fwd
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 1,  0, 0, 0, 0, 0, 1,  4, 1)); // jal x1,+8
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0,  4, 2)); // jump on a bubble
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  4, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  4, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  4, 2));

        for (int i = 0; i < tbl.size(); i++) begin
            apply_vec(tbl[i]);
            @(negedge clk);
            chk_fwd($sformatf("row%0d", i), tbl[i].e_sel0, tbl[i].e_sel1, tbl[i].e_src0, tbl[i].e_src1);
            chk_ctrl($sformatf("row%0d", i), tbl[i].e_stall, tbl[i].e_flush, 1'b0);
            chkc($sformatf("row%0d stall_cnt", i), stall_cnt, tbl[i].e_sc);
            chkc($sformatf("row%0d flush_cnt", i), flush_cnt, tbl[i].e_fc);
            tick();
        end

        // ebreak behind two ALU ops: three DRAIN cycles, then HALTED.
        set_in(1, 0, 0, 1, 0, 10, 1, 0, 0, 0);
        @(negedge clk);
        chk_ctrl("eb addi10", 1'b0, 1'b0, 1'b0);
        tick();
        set_in(1, 0, 0, 1, 0, 11, 1, 0, 0, 0);
        tick();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk_ctrl("eb issue", 1'b0, 1'b0, 1'b0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            resume = (k == 1);
            @(negedge clk);
            chk_ctrl($sformatf("drain%0d", k), 1'b1, 1'b0, 1'b0);
            tick();
        end
        resume = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk_ctrl($sformatf("halt%0d", k), 1'b1, 1'b0, 1'b1);
            tick();
        end
        chkc("halt stall_cnt", stall_cnt, CNT_W'(4));
        chkc("halt flush_cnt", flush_cnt, CNT_W'(2));
        resume = 1'b1;
        @(negedge clk);
        chk1("resume cycle halted", halted, 1'b1);
        tick();
        resume = 1'b0;
        @(negedge clk);
        chk_ctrl("after resume", 1'b0, 1'b0, 1'b0);
        chkc("after resume cycle_cnt", cycle_cnt, CNT_W'(tb_cycles));
        tick();

        // Reset asserted asynchronously in the middle of DRAIN.
        set_in(1, 0, 0, 1, 0, 12, 1, 0, 0, 0);
        tick();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        set_in(1, 12, 0, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk_ctrl("pre-rst drain", 1'b1, 1'b0, 1'b0);
        chk1("pre-rst sel0", forward_sel0, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        chk_ctrl("async rst", 1'b0, 1'b0, 1'b0);
        chk_fwd("async rst", 1'b0, 1'b0, 1'b0, 1'b0);
        chkc("async rst cycle_cnt", cycle_cnt, CNT_W'(0));
        chkc("async rst stall_cnt", stall_cnt, CNT_W'(0));
        chkc("async rst flush_cnt", flush_cnt, CNT_W'(0));
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        tb_cycles = 0;
        set_in(1, 12, 12, 1, 1, 13, 1, 0, 0, 0);
        @(negedge clk);
        chk_fwd("post-rst x12", 1'b0, 1'b0, 1'b0, 1'b0);
        chk_ctrl("post-rst x12", 1'b0, 1'b0, 1'b0);
        tick();
        set_in(1, 13, 13, 1, 1, 14, 1, 0, 0, 0);
        @(negedge clk);
        chk_ctrl("post-rst x13 ex", 1'b1, 1'b0, 1'b0);
        tick();
        @(negedge clk);
        chk_fwd("post-rst x13 mem", 1'b1, 1'b1, 1'b0, 1'b0);
        chk_ctrl("post-rst x13 mem", 1'b0, 1'b0, 1'b0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chkc("post-rst stall_cnt", stall_cnt, CNT_W'(1));
        chkc("post-rst cycle_cnt", cycle_cnt, CNT_W'(tb_cycles));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
